// File: rtl/aes_ark_pipe_if.sv
// Bus bundle for the AES AddRoundKey pipeline: key-write port, input beat, output beat.
interface aes_ark_pipe_if #(
  parameter int unsigned LANES = 1,
  parameter int unsigned RKW   = 4
);
  localparam int unsigned DW = 128 * LANES;

  logic           key_we;
  logic [RKW-1:0] key_idx;
  logic [127:0]   key_in;

  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [RKW-1:0] in_round;
  logic           in_bypass;

  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_err;

  modport master (
    output key_we, key_idx, key_in,
    output in_valid, in_data, in_round, in_bypass,
    output out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  key_we, key_idx, key_in,
    input  in_valid, in_data, in_round, in_bypass,
    input  out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/aes_ark_pipe.sv
// AES AddRoundKey pipeline: round-key file plus a STAGES-deep valid/ready pipe.
// The key XOR is computed into stage 0; later stages only carry data/valid/err.
module aes_ark_pipe #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned STAGES = 2,
  parameter int unsigned NRK    = 11
) (
  input logic           clk,
  input logic           rst,
  aes_ark_pipe_if.slave bus
);
  localparam int unsigned RKW   = (NRK > 1) ? $clog2(NRK) : 1;
  localparam int unsigned DW    = 128 * LANES;
  localparam logic [RKW:0] NRK_W = (RKW + 1)'(NRK);

  typedef struct packed {
    logic          valid;
    logic          err;
    logic [DW-1:0] data;
  } stage_t;

  logic [127:0]      key_q [NRK];
  logic [127:0]      key_d [NRK];
  stage_t            st_q  [STAGES];
  stage_t            st_d  [STAGES];
  logic [STAGES-1:0] ld;
  logic [127:0]      key_sel;
  logic [127:0]      key_mix;
  logic              round_err;
  logic [DW-1:0]     ark_data;

  // Key file next state; out-of-range slots match no entry and are dropped.
  always_comb begin
    for (int unsigned i = 0; i < NRK; i++) begin
      key_d[i] = key_q[i];
      if (bus.key_we && (bus.key_idx == RKW'(i))) begin
        key_d[i] = bus.key_in;
      end
    end
  end

  // Read the requested round key from the registered file (old value on same-cycle write).
  always_comb begin
    key_sel = '0;
    for (int unsigned i = 0; i < NRK; i++) begin
      if (bus.in_round == RKW'(i)) begin
        key_sel = key_q[i];
      end
    end
  end

  assign round_err = {1'b0, bus.in_round} >= NRK_W;
  // Word order of the key is reversed against the state words.
  assign key_mix   = {key_sel[31:0], key_sel[63:32], key_sel[95:64], key_sel[127:96]};

  // Apply the same key to every lane unless bypassed or the slot is invalid.
  always_comb begin
    ark_data = bus.in_data;
    if (!(bus.in_bypass || round_err)) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        ark_data[l*128 +: 128] = bus.in_data[l*128 +: 128] ^ key_mix;
      end
    end
  end

  // Load enables: a stage loads when empty or when the stage after it loads.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = !st_q[STAGES-1].valid || bus.out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      ld[i] = !st_q[i].valid || ld[i+1];
    end
  end

  // Pipeline next state: stage 0 takes the transformed beat, later stages shift.
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      st_d[s] = st_q[s];
    end
    if (ld[0]) begin
      st_d[0].valid = bus.in_valid;
      st_d[0].err   = bus.in_valid && round_err;
      if (bus.in_valid) begin
        st_d[0].data = ark_data;
      end
    end
    for (int unsigned s = 1; s < STAGES; s++) begin
      if (ld[s]) begin
        st_d[s].valid = st_q[s-1].valid;
        st_d[s].err   = st_q[s-1].valid && st_q[s-1].err;
        if (st_q[s-1].valid) begin
          st_d[s].data = st_q[s-1].data;
        end
      end
    end
  end

  // State registers; reset clears keys and drops any beat in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NRK; i++) begin
        key_q[i] <= '0;
      end
      for (int unsigned s = 0; s < STAGES; s++) begin
        st_q[s] <= '0;
      end
    end else begin
      key_q <= key_d;
      st_q  <= st_d;
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = st_q[STAGES-1].valid;
  assign bus.out_err   = st_q[STAGES-1].err;
  assign bus.out_data  = st_q[STAGES-1].data;
endmodule

// File: doc/aes_ark_pipe.md
AES_ARK_PIPE -- requirements
Module: aes_ark_pipe

Interface
REQ-001 Parameter LANES, default 1: number of 128-bit AES states carried per beat.
REQ-002 Parameter STAGES, default 2, legal range 1..4: number of register stages from input to output.
REQ-003 Parameter NRK, default 11: number of stored round keys. RKW = max(1, clog2(NRK)).
REQ-004 clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1: reset, asynchronous and active-low.
REQ-006 key_we  in  1: round-key write strobe.
REQ-007 key_idx  in  RKW: round-key write slot.
REQ-008 key_in  in  128: round-key value.
REQ-009 in_valid  in  1: input beat valid.
REQ-010 in_ready  out  1: the block can accept an input beat.
REQ-011 in_data  in  128*LANES: input states; lane L occupies bits [128L+127:128L].
REQ-012 in_round  in  RKW: round-key slot to apply to the beat.
REQ-013 in_bypass  in  1: pass the beat through without the key XOR.
REQ-014 out_valid  out  1: output beat valid.
REQ-015 out_ready  in  1: downstream accepts the output beat.
REQ-016 out_data  out  128*LANES: result states.
REQ-017 out_err  out  1: the beat requested a round slot with in_round >= NRK.

Function
REQ-018 Accept SHALL occur on a cycle where in_valid && in_ready; deliver SHALL occur on a cycle where out_valid && out_ready.
REQ-019 Each lane SHALL be transformed as follows, with k = key[in_round]:
- data[127:96] ^ k[31:0]
- data[95:64] ^ k[63:32]
- data[63:32] ^ k[95:64]
- data[31:0] ^ k[127:96]
The same key SHALL be applied to all lanes.
REQ-020 If in_bypass=1, or in_round >= NRK, the data SHALL be passed through unmodified.
REQ-021 out_err SHALL be 1 exactly when in_round >= NRK, travelling with its beat; in_bypass SHALL NOT suppress out_err.
REQ-022 The key XOR SHALL be computed into stage 0. Stages 1..STAGES-1 SHALL be plain data/valid/err registers. out_* SHALL be driven from the last stage.
REQ-023 Pipeline movement:
- Each stage holds a valid bit.
- A stage SHALL load from its predecessor when it is empty, or when it is itself advancing.
- The last stage advances on out_ready.
- No bubbles SHALL be inserted while in_valid and out_ready are held high.
REQ-024 in_ready SHALL equal !stage0_valid || stage0_advancing. It is combinational from out_ready through the valid chain, with no register.
REQ-025 Latency SHALL be STAGES cycles from accept to out_valid with out_ready held high. Sustained throughput SHALL be one beat per cycle.
REQ-026 While out_valid=1 && out_ready=0, out_data and out_err SHALL hold stable, and no stored beat SHALL be lost or duplicated.
REQ-027 A key write SHALL update slot key_idx at the clock edge.
REQ-028 A beat accepted in the same cycle as a write to its own slot SHALL use the old key (read-before-write).
REQ-029 A write with key_idx >= NRK SHALL be ignored.
REQ-030 Key slots SHALL NOT be affected by pipeline stall state.

Reset
REQ-031 While rst=0, the following SHALL be 0:
- all stage valid bits
- out_valid
- out_err
- out_data
- all NRK key slots
REQ-032 in_ready SHALL read 1 during reset and after reset release.
REQ-033 Assertion of rst mid-stream SHALL discard in-flight beats immediately; beats in flight are not delivered after release.

Verification
REQ-034 Basic transform: LANES=1, STAGES=2, key[0]=000102030405060708090a0b0c0d0e0f, in_data=00112233445566778899aabbccddeeff, in_round=0, out_ready=1 -> out_data=0c1c2c3c4c5c6c7c8c9cacbcccdcecfc and out_err=0, with out_valid exactly 2 cycles after accept.
REQ-035 Back-pressure: stream 8 beats with in_valid=1 while out_ready toggles 1,0,0,1,... -> all 8 results delivered in order, none dropped or duplicated, out_data stable while stalled, and in_ready=0 once both stages are full and stalled.
REQ-036 Bypass and error:
- Beat with in_bypass=1 and in_round=0 -> out_data equals in_data, out_err=0.
- Beat with in_round=NRK (11) -> out_data equals in_data, out_err=1.
REQ-037 Key hazard: in the same cycle, write key[3]=ffff...ff and accept a beat with in_round=3 -> that beat uses the old key[3]=0; the next beat with in_round=3 gets bitwise-inverted data.
REQ-038 Reset mid-operation: drop rst to 0 with 2 beats in flight -> out_valid=0 and out_data=0 immediately; after release no stale beat appears, key[0] reads 0 (a beat with in_round=0 returns in_data unchanged), and in_ready=1.
REQ-039 Lanes: LANES=2, lane 0 and lane 1 given different data with the same in_round -> each lane is XORed with the identical key, with lane ordering preserved.
